// File: rtl/gray_counter.sv
// Up/down counter holding binary and Gray copies of its state; loadable in either code, wraps or saturates.
// Latency: one clk edge from inputs to bin_out/gray_out/limit; no backpressure, one step per cycle.
// Backpressure: none; every enabled edge is consumed.
module gray_counter #(
    parameter int size      = 10,
    parameter bit wrap_mode = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            up_dn,
    input  logic            load,
    input  logic            load_gray,
    input  logic [size-1:0] load_val,
    output logic [size-1:0] bin_out,
    output logic [size-1:0] gray_out,
    output logic            limit
);

    localparam logic [size-1:0] ONE = {{(size-1){1'b0}}, 1'b1};

    logic [size-1:0] r_bin;
    logic [size-1:0] r_gray;
    logic            r_limit;

    logic [size-1:0] w_load_bin;
    logic [size-1:0] w_next_bin;
    logic [size-1:0] w_next_gray;
    logic            w_next_lim;
    logic            w_at_end;

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i < size; i++) begin : g_g2b
        assign w_load_bin[i] = ^(load_val >> i);
    end

    assign w_at_end = up_dn ? (&r_bin) : (~|r_bin);

    always_comb begin
        w_next_bin = r_bin;
        w_next_lim = 1'b0;
        if (load) begin
            w_next_bin = load_gray ? w_load_bin : load_val;
        end else if (en) begin
            w_next_lim = w_at_end;
            if (!w_at_end || wrap_mode) begin
                w_next_bin = up_dn ? (r_bin + ONE) : (r_bin - ONE);
            end
        end
    end

    // Gray copy is registered from the next value so the output never glitches.
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_limit <= 1'b0;
        end else begin
            r_bin   <= w_next_bin;
            r_gray  <= w_next_gray;
            r_limit <= w_next_lim;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign limit    = r_limit;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboarded bench: three counters (4-bit wrap, 4-bit saturate, 10-bit wrap) share one stimulus stream
// and are compared against an arithmetic reference model.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic       load_gray = 1'b0;
    logic [9:0] load_val = '0;

    logic [3:0] b0, g0, b1, g1;
    logic [9:0] b2, g2;
    logic       l0, l1, l2;

    always #5 clk = ~clk;

    gray_counter #(.size(4), .wrap_mode(1'b1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val[3:0]),
        .bin_out(b0), .gray_out(g0), .limit(l0));

    gray_counter #(.size(4), .wrap_mode(1'b0)) u_s4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val[3:0]),
        .bin_out(b1), .gray_out(g1), .limit(l1));

    gray_counter #(.size(10), .wrap_mode(1'b1)) u_w10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_out(b2), .gray_out(g2), .limit(l2));

    typedef struct {
        int bin;
        int gray;
        bit lim;
        bit step;
        int pgray;
    } exp_t;

    exp_t     sb [3][$];
    int       m_cnt [3];
    const int SZ [3] = '{4, 4, 10};
    const bit WR [3] = '{1'b1, 1'b0, 1'b1};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(string nm, int k, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", nm, k, $time, act, exp);
        end
    endtask

    function automatic int act_bin(int k);
        case (k)
            0: return int'(b0);
            1: return int'(b1);
            default: return int'(b2);
        endcase
    endfunction

    function automatic int act_gray(int k);
        case (k)
            0: return int'(g0);
            1: return int'(g1);
            default: return int'(g2);
        endcase
    endfunction

    function automatic int act_lim(int k);
        case (k)
            0: return int'(l0);
            1: return int'(l1);
            default: return int'(l2);
        endcase
    endfunction

    // Gray to binary: binary is the XOR of the Gray word shifted by every amount.
    function automatic int g2b(int g, int sz);
        int b = 0;
        for (int s = 0; s < sz; s++) b ^= (g >> s);
        return b;
    endfunction

    task automatic drive(bit l, bit lg, int v, bit e, bit u);
        @(negedge clk);
        rst_n = 1'b1;
        load = l; load_gray = lg; load_val = v[9:0]; en = e; up_dn = u;
        for (int k = 0; k < 3; k++) begin
            int mx  = (1 << SZ[k]) - 1;
            int cur = m_cnt[k];
            int nxt = cur;
            exp_t x;
            x.lim   = 1'b0;
            x.pgray = cur ^ (cur >> 1);
            if (l) begin
                nxt = lg ? g2b(v & mx, SZ[k]) : (v & mx);
            end else if (e) begin
                if (u) begin
                    if (cur == mx) begin x.lim = 1'b1; nxt = WR[k] ? 0 : mx; end
                    else nxt = cur + 1;
                end else begin
                    if (cur == 0) begin x.lim = 1'b1; nxt = WR[k] ? mx : 0; end
                    else nxt = cur - 1;
                end
            end
            x.step = !l && e && (nxt != cur);
            x.bin  = nxt;
            x.gray = nxt ^ (nxt >> 1);
            m_cnt[k] = nxt;
            sb[k].push_back(x);
        end
    endtask

    task automatic check_zero(string nm);
        for (int k = 0; k < 3; k++) begin
            chk({nm, "_bin"}, k, act_bin(k), 0);
            chk({nm, "_gray"}, k, act_gray(k), 0);
            chk({nm, "_lim"}, k, act_lim(k), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        #1;
        check_zero("async_rst");
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    endtask

    exp_t mon_x;
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (sb[k].size() > 0) begin
                mon_x = sb[k].pop_front();
                chk("bin", k, act_bin(k), mon_x.bin);
                chk("gray", k, act_gray(k), mon_x.gray);
                chk("limit", k, act_lim(k), int'(mon_x.lim));
                if (mon_x.step)
                    chk("gray_1bit", k, $countones(act_gray(k) ^ mon_x.pgray), 1);
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        #3;
        check_zero("reset");

        // Full wrap-around count up.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        // Gray load 1100 -> 8, binary load 6 -> Gray 0101.
        drive(1'b1, 1'b1, 'b1100, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 6, 1'b0, 1'b0);
        // Down step from zero.
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        // Saturation at max, then reverse.
        drive(1'b1, 1'b0, 14, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        // Load wins over enable.
        drive(1'b1, 1'b0, 3, 1'b1, 1'b1);
        // Hold.
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Count to 9, async reset between edges, resume.
        do_reset();
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        do_reset();
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);

        for (int i = 0; i < 600; i++) begin
            int v;
            case ($urandom_range(3))
                0: v = 0;
                1: v = 1023;
                default: v = int'($urandom_range(1023));
            endcase
            drive($urandom_range(9) == 0, 1'($urandom_range(1)), v,
                  $urandom_range(3) != 0, 1'($urandom_range(1)));
        end

        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("sb_drained", k, sb[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
